// File: rtl/data_acc_pkg.sv
// -----------------------------------------------------------------------------
// data_acc_pkg
// Shared configuration for the multi-lane correlator accumulator: data widths,
// lane count, lane-index width, drain FSM state type and the saturating adder
// used by every lane.
// -----------------------------------------------------------------------------
package data_acc_pkg;

    localparam int ACC_DATA_WIDTH = 16;  // accumulator / result width, two's complement
    localparam int IQ_DATA_WIDTH  = 6;   // wiped-off sample width, two's complement
    localparam int CHANNEL_NUM    = 3;   // number of code-phase lanes, >= 1
    localparam int COH_CNT_WIDTH  = 8;   // coherent length counter width
    localparam int IDX_WIDTH      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    typedef logic [ACC_DATA_WIDTH-1:0] acc_t;
    typedef logic [IQ_DATA_WIDTH-1:0]  iq_t;
    typedef logic [IDX_WIDTH-1:0]      idx_t;
    typedef logic [COH_CNT_WIDTH-1:0]  coh_t;

    localparam idx_t LAST_IDX = idx_t'(CHANNEL_NUM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } drain_state_t;

    // acc + sign_ext(sample) evaluated one bit wider than the accumulator so
    // overflow shows up as a disagreement between the top two bits.
    function automatic acc_t sat_add(input acc_t acc, input iq_t sample, input logic sat_en);
        logic [ACC_DATA_WIDTH:0] sum;
        sum = {acc[ACC_DATA_WIDTH-1], acc}
            + {{(ACC_DATA_WIDTH + 1 - IQ_DATA_WIDTH){sample[IQ_DATA_WIDTH-1]}}, sample};
        if (sat_en && (sum[ACC_DATA_WIDTH] != sum[ACC_DATA_WIDTH-1])) begin
            return sum[ACC_DATA_WIDTH] ? {1'b1, {(ACC_DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_DATA_WIDTH-1){1'b1}}};
        end
        return sum[ACC_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/data_acc_if.sv
// -----------------------------------------------------------------------------
// data_acc_if
// Dump port of the correlator accumulator: frozen coherent sums drained one
// lane per accepted word over a valid/ready handshake.
//   dump_valid  master->slave  word valid
//   dump_ready  slave->master  consumer accepts word
//   dump_idx    master->slave  lane of current word
//   dump_i/q    master->slave  frozen coherent sums
//   dump_last   master->slave  dump_idx is the last lane
// -----------------------------------------------------------------------------
interface data_acc_if;
    import data_acc_pkg::*;

    logic dump_valid;
    logic dump_ready;
    idx_t dump_idx;
    acc_t dump_i;
    acc_t dump_q;
    logic dump_last;

    modport master (
        output dump_valid, dump_idx, dump_i, dump_q, dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid, dump_idx, dump_i, dump_q, dump_last,
        output dump_ready
    );

endinterface

// File: rtl/data_acc_lane.sv
// -----------------------------------------------------------------------------
// data_acc_lane
// One correlator lane: selects the positive or negative wiped-off sample by
// the lane's PRN bit and accumulates it with optional saturation.
//   clk, rst            clock, synchronous active-high reset
//   i_load, i_load_i/q  context restore of this lane (highest priority)
//   i_clear             zero the lane
//   i_accept            sample accepted this cycle
//   i_restart           coherent dump: lane restarts from zero
//   i_prn, i_sat_en     code bit, 1 = clamp on overflow
//   i_pos_*, i_neg_*    samples for prn bit 0 / 1
//   o_acc_i/q           live accumulator
//   o_sum_i/q           accumulator plus current sample (dump value)
// -----------------------------------------------------------------------------
module data_acc_lane
    import data_acc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  acc_t i_load_i,
    input  acc_t i_load_q,
    input  logic i_clear,
    input  logic i_accept,
    input  logic i_restart,
    input  logic i_prn,
    input  logic i_sat_en,
    input  iq_t  i_pos_i,
    input  iq_t  i_pos_q,
    input  iq_t  i_neg_i,
    input  iq_t  i_neg_q,
    output acc_t o_acc_i,
    output acc_t o_acc_q,
    output acc_t o_sum_i,
    output acc_t o_sum_q
);

    acc_t r_acc_i;
    acc_t r_acc_q;
    iq_t  w_sel_i;
    iq_t  w_sel_q;

    assign w_sel_i = i_prn ? i_neg_i : i_pos_i;
    assign w_sel_q = i_prn ? i_neg_q : i_pos_q;

    assign o_sum_i = sat_add(r_acc_i, w_sel_i, i_sat_en);
    assign o_sum_q = sat_add(r_acc_q, w_sel_q, i_sat_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_load) begin
            r_acc_i <= i_load_i;
            r_acc_q <= i_load_q;
        end else if (i_clear) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_accept) begin
            // On a dump the sum including this sample goes to the shadow
            // buffer; the lane itself starts the next period from zero.
            r_acc_i <= i_restart ? '0 : o_sum_i;
            r_acc_q <= i_restart ? '0 : o_sum_q;
        end
    end

    assign o_acc_i = r_acc_i;
    assign o_acc_q = r_acc_q;

endmodule

// File: rtl/data_acc_array.sv
// -----------------------------------------------------------------------------
// data_acc_array
// Multi-lane correlator accumulator. CHANNEL_NUM lanes share one I/Q sample
// stream; a shared coherent-length counter triggers dumps that freeze all lane
// sums into a shadow buffer, which is then drained lane by lane.
//   clk, rst                    clock, synchronous active-high reset
//   acc_in_en/idx, i/q_acc_i    context restore of one lane
//   acc_clear                   zero all lanes and the coherent counter
//   data_valid, *_data_pos/neg  sample strobe and samples for prn 0 / 1
//   prn_code                    per-lane code bit
//   coh_length                  samples per coherent dump, 0 = no dumps
//   sat_en                      1 = clamp on overflow, 0 = wrap
//   i_acc_o, q_acc_o            live accumulators, lane k at [k*ACC +: ACC]
//   dump                        dump port (valid/ready, idx, i/q, last)
//   overrun, overrun_clr        sticky lost-dump flag and its clear
// -----------------------------------------------------------------------------
module data_acc_array
    import data_acc_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  acc_in_en,
    input  idx_t                                  acc_in_idx,
    input  acc_t                                  i_acc_i,
    input  acc_t                                  q_acc_i,
    input  logic                                  acc_clear,
    input  logic                                  data_valid,
    input  iq_t                                   i_data_pos,
    input  iq_t                                   q_data_pos,
    input  iq_t                                   i_data_neg,
    input  iq_t                                   q_data_neg,
    input  logic [CHANNEL_NUM-1:0]                prn_code,
    input  coh_t                                  coh_length,
    input  logic                                  sat_en,
    output logic [CHANNEL_NUM*ACC_DATA_WIDTH-1:0] i_acc_o,
    output logic [CHANNEL_NUM*ACC_DATA_WIDTH-1:0] q_acc_o,
    data_acc_if.master                            dump,
    output logic                                  overrun,
    input  logic                                  overrun_clr
);

    coh_t         r_coh_cnt;
    drain_state_t r_state;
    logic         r_dump_valid;
    idx_t         r_dump_idx;
    logic         r_overrun;
    acc_t         r_shadow_i [CHANNEL_NUM];
    acc_t         r_shadow_q [CHANNEL_NUM];

    acc_t         w_sum_i [CHANNEL_NUM];
    acc_t         w_sum_q [CHANNEL_NUM];
    logic         w_accept;
    logic         w_dump_event;
    logic         w_final_hs;
    logic         w_overrun_set;

    // A restore or clear in the same cycle drops the sample for every lane.
    assign w_accept      = data_valid && !acc_in_en && !acc_clear;
    assign w_dump_event  = w_accept && (coh_length != '0)
                        && (r_coh_cnt == coh_length - coh_t'(1));
    assign w_final_hs    = (r_state == ST_DRAIN) && dump.dump_ready && (r_dump_idx == LAST_IDX);
    assign w_overrun_set = w_dump_event && (r_state == ST_DRAIN) && !w_final_hs;

    genvar k;
    generate
        for (k = 0; k < CHANNEL_NUM; k++) begin : g_lane
            data_acc_lane u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_load   (acc_in_en && (acc_in_idx == idx_t'(k))),
                .i_load_i (i_acc_i),
                .i_load_q (q_acc_i),
                .i_clear  (acc_clear),
                .i_accept (w_accept),
                .i_restart(w_dump_event),
                .i_prn    (prn_code[k]),
                .i_sat_en (sat_en),
                .i_pos_i  (i_data_pos),
                .i_pos_q  (q_data_pos),
                .i_neg_i  (i_data_neg),
                .i_neg_q  (q_data_neg),
                .o_acc_i  (i_acc_o[k*ACC_DATA_WIDTH +: ACC_DATA_WIDTH]),
                .o_acc_q  (q_acc_o[k*ACC_DATA_WIDTH +: ACC_DATA_WIDTH]),
                .o_sum_i  (w_sum_i[k]),
                .o_sum_q  (w_sum_q[k])
            );
        end
    endgenerate

    // Coherent counter: holds across a restore, wraps freely if coh_length is
    // lowered below the current count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coh_cnt <= '0;
        end else if (!acc_in_en) begin
            if (acc_clear) begin
                r_coh_cnt <= '0;
            end else if (data_valid) begin
                if ((coh_length == '0) || w_dump_event) begin
                    r_coh_cnt <= '0;
                end else begin
                    r_coh_cnt <= r_coh_cnt + coh_t'(1);
                end
            end
        end
    end

    // Drain FSM. The shadow buffer is only written from IDLE or on the cycle
    // of the final handshake, so the word on the port never changes while
    // it is waiting for ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= '0;
            r_overrun    <= 1'b0;
            for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                r_shadow_i[i] <= '0;
                r_shadow_q[i] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_dump_event) begin
                        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                            r_shadow_i[i] <= w_sum_i[i];
                            r_shadow_q[i] <= w_sum_q[i];
                        end
                        r_dump_idx   <= '0;
                        r_dump_valid <= 1'b1;
                        r_state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dump.dump_ready) begin
                        if (r_dump_idx == LAST_IDX) begin
                            r_dump_idx <= '0;
                            if (w_dump_event) begin
                                for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                                    r_shadow_i[i] <= w_sum_i[i];
                                    r_shadow_q[i] <= w_sum_q[i];
                                end
                            end else begin
                                r_dump_valid <= 1'b0;
                                r_state      <= ST_IDLE;
                            end
                        end else begin
                            r_dump_idx <= r_dump_idx + idx_t'(1);
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_dump_valid <= 1'b0;
                end
            endcase

            // A new overrun wins over a simultaneous clear.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dump.dump_valid = r_dump_valid;
    assign dump.dump_idx   = r_dump_idx;
    assign dump.dump_i     = r_shadow_i[r_dump_idx];
    assign dump.dump_q     = r_shadow_q[r_dump_idx];
    assign dump.dump_last  = (r_dump_idx == LAST_IDX);
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_data_acc_array.sv
module tb_data_acc_array;
    import data_acc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, acc_in_en, acc_clear, data_valid, sat_en, overrun, overrun_clr;
    idx_t acc_in_idx;
    acc_t i_acc_i, q_acc_i;
    iq_t  i_data_pos, q_data_pos, i_data_neg, q_data_neg;
    logic [CHANNEL_NUM-1:0] prn_code;
    coh_t coh_length;
    logic [CHANNEL_NUM*ACC_DATA_WIDTH-1:0] i_acc_o, q_acc_o;

    data_acc_if dif ();

    data_acc_array dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in_en  (acc_in_en),
        .acc_in_idx (acc_in_idx),
        .i_acc_i    (i_acc_i),
        .q_acc_i    (q_acc_i),
        .acc_clear  (acc_clear),
        .data_valid (data_valid),
        .i_data_pos (i_data_pos),
        .q_data_pos (q_data_pos),
        .i_data_neg (i_data_neg),
        .q_data_neg (q_data_neg),
        .prn_code   (prn_code),
        .coh_length (coh_length),
        .sat_en     (sat_en),
        .i_acc_o    (i_acc_o),
        .q_acc_o    (q_acc_o),
        .dump       (dif),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        idx_t idx;
        acc_t i;
        acc_t q;
        logic last;
    } dump_t;

    dump_t exp_q[$];
    dump_t mon_e;

    typedef struct {
        acc_t load;
        iq_t  smp;
        logic sat;
        acc_t exp;
    } sat_vec_t;

    sat_vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int idx, input int vi, input int vq);
        dump_t d;
        d.idx  = idx_t'(idx);
        d.i    = acc_t'(vi);
        d.q    = acc_t'(vq);
        d.last = (idx == CHANNEL_NUM - 1);
        exp_q.push_back(d);
    endtask

    task automatic sample(input int ip, input int qp, input int in_, input int qn);
        data_valid = 1'b1;
        i_data_pos = iq_t'(ip);
        q_data_pos = iq_t'(qp);
        i_data_neg = iq_t'(in_);
        q_data_neg = iq_t'(qn);
        cycle();
        data_valid = 1'b0;
    endtask

    task automatic clear_all();
        acc_clear = 1'b1;
        cycle();
        acc_clear = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || dif.dump_valid) && n < 60) begin
            cycle();
            n++;
        end
        check(name, {63'd0, (exp_q.size() == 0) && !dif.dump_valid}, 64'd1);
    endtask

    function automatic acc_t lane_i(input int k);
        return i_acc_o[k*ACC_DATA_WIDTH +: ACC_DATA_WIDTH];
    endfunction

    function automatic acc_t lane_q(input int k);
        return q_acc_o[k*ACC_DATA_WIDTH +: ACC_DATA_WIDTH];
    endfunction

    // Scoreboard: a word seen valid&ready before the edge is accepted at it.
    always @(negedge clk) begin
        if (!rst && dif.dump_valid && dif.dump_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dump: got idx=%0d i=%0h q=%0h expected no word",
                         dif.dump_idx, dif.dump_i, dif.dump_q);
            end else begin
                mon_e = exp_q.pop_front();
                check("dump_idx",  dif.dump_idx,  mon_e.idx);
                check("dump_i",    dif.dump_i,    mon_e.i);
                check("dump_q",    dif.dump_q,    mon_e.q);
                check("dump_last", dif.dump_last, mon_e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;

        vt[0] = '{16'h7FFE, 6'd31,  1'b1, 16'h7FFF};
        vt[1] = '{16'h7FFE, 6'd31,  1'b0, 16'h801D};
        vt[2] = '{16'h8001, 6'h20,  1'b1, 16'h8000};
        vt[3] = '{16'h8001, 6'h20,  1'b0, 16'h7FE1};
        vt[4] = '{16'h0010, 6'h3B,  1'b1, 16'h000B};
        vt[5] = '{16'hFFFF, 6'd1,   1'b0, 16'h0000};

        rst = 1'b1; acc_in_en = 1'b0; acc_in_idx = '0; i_acc_i = '0; q_acc_i = '0;
        acc_clear = 1'b0; data_valid = 1'b0; i_data_pos = '0; q_data_pos = '0;
        i_data_neg = '0; q_data_neg = '0; prn_code = '0; coh_length = '0;
        sat_en = 1'b0; overrun_clr = 1'b0; dif.dump_ready = 1'b1;
        cycle();
        cycle();
        check("rst_valid",   dif.dump_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_idx",     dif.dump_idx, 0);
        check("rst_acc_i",   i_acc_o, 0);
        rst = 1'b0;

        // 1: four +5/-2 samples per lane, coh_length 4
        coh_length = 8'd4;
        clear_all();
        for (int k = 0; k < CHANNEL_NUM; k++) push_word(k, 20, -8);
        for (int s = 0; s < 3; s++) sample(5, -2, 0, 0);
        check("t1_no_early_dump", dif.dump_valid, 0);
        sample(5, -2, 0, 0);
        check("t1_valid_latency", dif.dump_valid, 1);
        check("t1_acc_i_restart", i_acc_o, 0);
        check("t1_acc_q_restart", q_acc_o, 0);
        wait_drain("t1_drained");

        // 2: lane 1 on the negative sample
        clear_all();
        coh_length = 8'd2;
        prn_code   = 3'b010;
        push_word(0, 2, 4);
        push_word(1, -6, 14);
        push_word(2, 2, 4);
        sample(1, 2, -3, 7);
        sample(1, 2, -3, 7);
        wait_drain("t2_drained");
        prn_code = '0;

        // 3: saturation / wrap table on lane 0
        coh_length = '0;
        for (int v = 0; v < 6; v++) begin
            acc_in_en  = 1'b1;
            acc_in_idx = '0;
            i_acc_i    = vt[v].load;
            q_acc_i    = vt[v].load;
            cycle();
            acc_in_en = 1'b0;
            sat_en    = vt[v].sat;
            sample(int'($signed(vt[v].smp)), int'($signed(vt[v].smp)), 0, 0);
            check($sformatf("t3_sat_i_%0d", v), lane_i(0), vt[v].exp);
            check($sformatf("t3_sat_q_%0d", v), lane_q(0), vt[v].exp);
        end
        sat_en = 1'b0;

        // 4: consumer stalls, second dump is lost
        clear_all();
        coh_length     = 8'd2;
        dif.dump_ready = 1'b0;
        for (int k = 0; k < CHANNEL_NUM; k++) push_word(k, 8, 0);
        sample(4, 0, 0, 0);
        sample(4, 0, 0, 0);
        check("t4_valid", dif.dump_valid, 1);
        check("t4_no_overrun_yet", overrun, 0);
        sample(9, 0, 0, 0);
        sample(9, 0, 0, 0);
        check("t4_overrun_set", overrun, 1);
        check("t4_dump_i_held", dif.dump_i, 8);
        check("t4_acc_restart", lane_i(0), 0);
        sample(1, 0, 0, 0);
        overrun_clr = 1'b1;
        sample(1, 0, 0, 0);
        check("t4_set_wins", overrun, 1);
        overrun_clr = 1'b0;
        for (int s = 0; s < 4; s++) cycle();
        check("t4_idx_stable", dif.dump_idx, 0);
        check("t4_dump_i_stable", dif.dump_i, 8);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("t4_overrun_clr", overrun, 0);
        dif.dump_ready = 1'b1;
        wait_drain("t4_drained");

        // 7: dump events coinciding with the final handshake
        clear_all();
        coh_length = 8'd3;
        for (int e = 0; e < 3; e++)
            for (int k = 0; k < CHANNEL_NUM; k++) push_word(k, 3, 6);
        for (int s = 0; s < 9; s++) sample(1, 2, 0, 0);
        wait_drain("t7_drained");
        check("t7_no_overrun", overrun, 0);

        // 5: restore beats a sample; clear restarts the period
        clear_all();
        coh_length = 8'd4;
        sample(2, 0, 0, 0);
        acc_in_en  = 1'b1;
        acc_in_idx = idx_t'(1);
        i_acc_i    = 16'd100;
        q_acc_i    = 16'd50;
        sample(2, 0, 0, 0);
        acc_in_en = 1'b0;
        check("t5_lane0_hold", lane_i(0), 2);
        check("t5_lane1_load_i", lane_i(1), 100);
        check("t5_lane1_load_q", lane_q(1), 50);
        check("t5_lane2_hold", lane_i(2), 2);
        push_word(0, 8, 0);
        push_word(1, 106, 50);
        push_word(2, 8, 0);
        sample(2, 0, 0, 0);
        sample(2, 0, 0, 0);
        check("t5_cnt_held", dif.dump_valid, 0);
        sample(2, 0, 0, 0);
        wait_drain("t5_drained");
        sample(1, 0, 0, 0);
        sample(1, 0, 0, 0);
        clear_all();
        check("t5_clear_acc", lane_i(0), 0);
        for (int k = 0; k < CHANNEL_NUM; k++) push_word(k, 4, 0);
        for (int s = 0; s < 3; s++) sample(1, 0, 0, 0);
        check("t5_clear_restarts_cnt", dif.dump_valid, 0);
        sample(1, 0, 0, 0);
        wait_drain("t5_clear_drained");

        // 6: reset mid-drain, then dumping disabled
        clear_all();
        coh_length     = 8'd2;
        dif.dump_ready = 1'b0;
        sample(3, 1, 0, 0);
        sample(3, 1, 0, 0);
        check("t6_valid_before_rst", dif.dump_valid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_rst_valid", dif.dump_valid, 0);
        check("t6_rst_dump_i", dif.dump_i, 0);
        check("t6_rst_dump_q", dif.dump_q, 0);
        check("t6_rst_idx", dif.dump_idx, 0);
        check("t6_rst_acc", i_acc_o, 0);
        dif.dump_ready = 1'b1;
        coh_length     = '0;
        cnt = 0;
        for (int s = 0; s < 300; s++) begin
            sample(1, 1, 0, 0);
            if (dif.dump_valid) cnt++;
        end
        check("t6_no_dump_coh0", cnt, 0);
        check("t6_acc_300_i", lane_i(0), 300);
        check("t6_acc_300_q", lane_q(2), 300);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
